// File: rtl/water_dispenser_pkg.sv
// Shared types and defaults for the water_dispenser front end and its
// dispense_controller back end.
package water_dispenser_pkg;

    localparam int unsigned DEFAULT_AMOUNT_WIDTH    = 16;
    localparam int unsigned SWITCH_COUNT            = 4;
    localparam int unsigned DEFAULT_PULSES_PER_UNIT = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 1000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DISPENSING = 2'd1,
        ST_FAULT      = 2'd2
    } disp_state_e;

endpackage

// File: rtl/flow_edge_detector.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Also used for other asynchronous sensor inputs.
module flow_edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sig_i,
    output logic edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;
    logic edge_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= sig_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/dispense_controller.sv
// Opens the valve for an accepted amount and counts flow-meter pulses until
// it is delivered; handles cancel and the no-flow timeout fault.
module dispense_controller
    import water_dispenser_pkg::*;
#(
    parameter int unsigned AMOUNT_WIDTH    = DEFAULT_AMOUNT_WIDTH,
    parameter int unsigned PULSES_PER_UNIT = DEFAULT_PULSES_PER_UNIT,
    parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AMOUNT_WIDTH-1:0] amount,
    input  logic                    cancel,
    input  logic                    flow_pulse,
    output logic                    valve_open,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic                    fault,
    output logic [AMOUNT_WIDTH-1:0] dispensed,
    output logic [AMOUNT_WIDTH-1:0] remaining
);

    localparam int unsigned SUB_W = (PULSES_PER_UNIT > 1) ? $clog2(PULSES_PER_UNIT) : 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [SUB_W-1:0]        SUB_LAST = SUB_W'(PULSES_PER_UNIT - 1);
    localparam logic [TMO_W-1:0]        TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [AMOUNT_WIDTH-1:0] ONE_UNIT = AMOUNT_WIDTH'(1);

    disp_state_e             state_q;
    logic [SUB_W-1:0]        sub_q;
    logic [TMO_W-1:0]        tmo_q;
    logic [AMOUNT_WIDTH-1:0] dispensed_q;
    logic [AMOUNT_WIDTH-1:0] remaining_q;
    logic                    valve_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    aborted_q;
    logic                    fault_q;
    logic                    flow_edge;

    flow_edge_detector u_flow_edge (
        .clock  (clock),
        .reset  (reset),
        .sig_i  (flow_pulse),
        .edge_o (flow_edge)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sub_q       <= '0;
            tmo_q       <= '0;
            dispensed_q <= '0;
            remaining_q <= '0;
            valve_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        dispensed_q <= '0;
                        sub_q       <= '0;
                        tmo_q       <= '0;
                        if (amount != '0) begin
                            state_q     <= ST_DISPENSING;
                            remaining_q <= amount;
                            valve_q     <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            remaining_q <= '0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                ST_DISPENSING: begin
                    // Cancel outranks both a same-cycle flow edge and the timeout.
                    if (cancel) begin
                        state_q     <= ST_IDLE;
                        remaining_q <= '0;
                        valve_q     <= 1'b0;
                        busy_q      <= 1'b0;
                        aborted_q   <= 1'b1;
                    end else if (flow_edge) begin
                        tmo_q <= '0;
                        if (sub_q == SUB_LAST) begin
                            sub_q       <= '0;
                            dispensed_q <= dispensed_q + ONE_UNIT;
                            remaining_q <= remaining_q - ONE_UNIT;
                            if (remaining_q == ONE_UNIT) begin
                                state_q <= ST_IDLE;
                                valve_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            sub_q <= sub_q + SUB_W'(1);
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_FAULT;
                        valve_q <= 1'b0;
                        busy_q  <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (cancel) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valve_q <= 1'b0;
                    busy_q  <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    assign valve_open = valve_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign fault      = fault_q;
    assign dispensed  = dispensed_q;
    assign remaining  = remaining_q;

endmodule

// File: tb/tb_dispense_controller.sv
// Directed bench for dispense_controller with 4 pulses per unit and a
// 50-cycle no-flow timeout.
module tb_dispense_controller;

    localparam int unsigned AW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] amount;
    logic          cancel;
    logic          flow_pulse;
    logic          valve_open;
    logic          busy;
    logic          done;
    logic          aborted;
    logic          fault;
    logic [AW-1:0] dispensed;
    logic [AW-1:0] remaining;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int excl_viol = 0;

    dispense_controller #(
        .AMOUNT_WIDTH    (AW),
        .PULSES_PER_UNIT (4),
        .TIMEOUT_CYCLES  (50)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .cancel     (cancel),
        .flow_pulse (flow_pulse),
        .valve_open (valve_open),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .fault      (fault),
        .dispensed  (dispensed),
        .remaining  (remaining)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1)    done_cnt++;
        if (aborted === 1'b1) abort_cnt++;
        if ((32'(done) + 32'(aborted) + 32'(fault)) > 1) excl_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One flow-meter pulse; the resulting edge is counted 4 cycles after it rises.
    task automatic pulse_flow();
        flow_pulse = 1'b1;
        cyc(2);
        flow_pulse = 1'b0;
        cyc(4);
    endtask

    task automatic do_start(input logic [AW-1:0] amt);
        start  = 1'b1;
        amount = amt;
        cyc(1);
        start  = 1'b0;
    endtask

    int base_done;
    int base_abort;

    initial begin
        reset = 1'b1; start = 1'b0; amount = '0; cancel = 1'b0; flow_pulse = 1'b0;

        // 1: reset and idle flow
        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_valve", 32'(valve_open), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_abort", 32'(aborted), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_disp", 32'(dispensed), 0);
        check("rst_rem", 32'(remaining), 0);
        cancel = 1'b1; cyc(1); cancel = 1'b0;
        for (int i = 0; i < 5; i++) pulse_flow();
        check("idle_flow_disp", 32'(dispensed), 0);
        check("idle_flow_valve", 32'(valve_open), 0);

        // 2: normal job of 3 units
        base_done = done_cnt;
        do_start(16'd3);
        check("t2_valve", 32'(valve_open), 1);
        check("t2_busy", 32'(busy), 1);
        check("t2_rem0", 32'(remaining), 3);
        check("t2_disp0", 32'(dispensed), 0);
        for (int i = 1; i <= 12; i++) begin
            pulse_flow();
            if (i % 4 == 0) begin
                check("t2_disp", 32'(dispensed), 32'(i / 4));
                check("t2_rem", 32'(remaining), 32'(3 - i / 4));
            end
            if (i == 11) check("t2_valve_11", 32'(valve_open), 1);
        end
        check("t2_done_cnt", 32'(done_cnt - base_done), 1);
        check("t2_valve_end", 32'(valve_open), 0);
        check("t2_busy_end", 32'(busy), 0);

        // 3: cancel mid-job, then new job clears dispensed
        base_abort = abort_cnt;
        do_start(16'd5);
        for (int i = 0; i < 9; i++) pulse_flow();
        check("t3_disp_pre", 32'(dispensed), 2);
        cancel = 1'b1; cyc(1); cancel = 1'b0;
        check("t3_aborted", 32'(aborted), 1);
        check("t3_valve", 32'(valve_open), 0);
        check("t3_disp", 32'(dispensed), 2);
        check("t3_rem", 32'(remaining), 0);
        cyc(1);
        check("t3_aborted_off", 32'(aborted), 0);
        check("t3_abort_cnt", 32'(abort_cnt - base_abort), 1);
        do_start(16'd1);
        check("t3_new_disp", 32'(dispensed), 0);
        check("t3_new_rem", 32'(remaining), 1);
        base_done = done_cnt;
        for (int i = 0; i < 4; i++) pulse_flow();
        check("t3_new_done", 32'(done_cnt - base_done), 1);
        check("t3_new_disp_end", 32'(dispensed), 1);

        // 4: no-flow timeout
        base_abort = abort_cnt;
        do_start(16'd2);
        cyc(49);
        check("t4_fault_early", 32'(fault), 0);
        check("t4_valve_early", 32'(valve_open), 1);
        cyc(1);
        check("t4_fault", 32'(fault), 1);
        check("t4_valve", 32'(valve_open), 0);
        check("t4_busy", 32'(busy), 0);
        do_start(16'd7);
        check("t4_start_ign_fault", 32'(fault), 1);
        check("t4_start_ign_rem", 32'(remaining), 2);
        check("t4_start_ign_valve", 32'(valve_open), 0);
        pulse_flow();
        check("t4_flow_ign", 32'(dispensed), 0);
        cancel = 1'b1; cyc(1); cancel = 1'b0;
        check("t4_fault_clr", 32'(fault), 0);
        check("t4_no_abort", 32'(abort_cnt - base_abort), 0);
        cyc(1);
        check("t4_idle_busy", 32'(busy), 0);

        // 5: zero amount and start while busy
        do_start(16'd0);
        check("t5_done", 32'(done), 1);
        check("t5_valve", 32'(valve_open), 0);
        check("t5_disp", 32'(dispensed), 0);
        check("t5_rem", 32'(remaining), 0);
        cyc(1);
        check("t5_done_off", 32'(done), 0);
        check("t5_valve2", 32'(valve_open), 0);
        do_start(16'd4);
        cyc(1);
        do_start(16'd9);
        check("t5_busy_ign_rem", 32'(remaining), 4);
        check("t5_busy_ign_busy", 32'(busy), 1);
        cancel = 1'b1; cyc(1); cancel = 1'b0;
        cyc(1);

        // 6: cancel coincides with the completing edge, then reset mid-job
        base_done = done_cnt;
        do_start(16'd1);
        for (int i = 0; i < 3; i++) pulse_flow();
        flow_pulse = 1'b1;
        cyc(2);
        flow_pulse = 1'b0;
        cyc(1);
        cancel = 1'b1;
        cyc(1);
        cancel = 1'b0;
        check("t6_aborted", 32'(aborted), 1);
        check("t6_not_done", 32'(done), 0);
        check("t6_disp", 32'(dispensed), 0);
        check("t6_rem", 32'(remaining), 0);
        cyc(3);
        check("t6_done_cnt", 32'(done_cnt - base_done), 0);
        do_start(16'd6);
        for (int i = 0; i < 5; i++) pulse_flow();
        check("t6_mid_disp", 32'(dispensed), 1);
        reset = 1'b1;
        cyc(1);
        check("t6_rst_valve", 32'(valve_open), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_disp", 32'(dispensed), 0);
        check("t6_rst_rem", 32'(remaining), 0);
        check("t6_rst_flags", {29'd0, done, aborted, fault}, 0);
        reset = 1'b0;
        cyc(2);

        check("excl_outputs", 32'(excl_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
